hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL take parameter REG_ADDR_W, default 5, meaning register index width (NUM_REGS = 2**REG_ADDR_W).
REQ-002 SHALL take parameter LAT_W, default 3, meaning result-latency width (max latency 2**LAT_W-1).
REQ-003 SHALL take parameter CNT_W, default 16, meaning stall performance counter width.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port id_valid  input  1  IF/ID holds a live instruction.
REQ-007 SHALL have ports id_rs1, id_rs2  input  REG_ADDR_W  source indices of the ID instruction.
REQ-008 SHALL have ports id_rs1_used, id_rs2_used  input  1  the corresponding source is actually read.
REQ-009 SHALL have port id_rd  input  REG_ADDR_W  destination index of the ID instruction.
REQ-010 SHALL have port id_reg_write  input  1  ID instruction writes id_rd.
REQ-011 SHALL have port id_latency  input  LAT_W  cycles until the result is forwardable (0 ALU, 1 load, >1 multicycle).
REQ-012 SHALL have port flush  input  1  ID instruction is killed this cycle (branch/jump redirect).
REQ-013 SHALL have port stall_cnt_clr  input  1  synchronous clear of the stall counter.
REQ-014 SHALL have port stall  output  1  hold PC and IF/ID, bubble ID/EX.
REQ-015 SHALL have port hazard_detection_src  output  1  equals ~stall (PC/IF-ID write enable, ID/EX control select).
REQ-016 SHALL have port busy  output  NUM_REGS  bit r set while register r has a pending result.
REQ-017 SHALL have port stall_cycles  output  CNT_W  saturating count of stalled cycles.

Function
REQ-018 SHALL keep one LAT_W-bit countdown cnt[r] per register; busy[r] = (cnt[r] != 0).
REQ-019 SHALL assert raw_hit when (id_rs1_used and id_rs1 != 0 and cnt[id_rs1] != 0) or the same condition holds for rs2.
REQ-020 SHALL assert waw_hit when id_reg_write, id_rd != 0 and cnt[id_rd] > id_latency (prevents out-of-order writeback).
REQ-021 SHALL drive stall = id_valid and not flush and (raw_hit or waw_hit), combinationally from registered cnt and current inputs.
REQ-022 SHALL issue when id_valid and not flush and not stall and id_reg_write and id_rd != 0; issue loads cnt[id_rd] <= id_latency on the next edge.
REQ-023 SHALL decrement every nonzero cnt[r] not being loaded by one each cycle, saturating at 0.
REQ-024 SHALL let a same-cycle issue to register r override its decrement.
REQ-025 SHALL treat register 0 as never busy: cnt[0] stays 0, no RAW/WAW on index 0.
REQ-026 SHALL stall a consumer entering ID one cycle after its producer issues for exactly id_latency cycles (load: 1 bubble; ALU: 0).
REQ-027 SHALL let flush suppress both stall and issue in the same cycle; pending counters keep counting (in-flight ops are never cancelled).
REQ-028 SHALL increment stall_cycles by 1 on each cycle stall=1, holding at 2**CNT_W-1; stall_cnt_clr wins over increment.

Reset
REQ-029 SHALL, while rst_n=0 and independent of clk, clear all cnt[r], busy and stall_cycles to 0; stall=0 and hazard_detection_src=1 (given id_valid=0 or no hits).
REQ-030 SHALL, on reset assertion mid-operation, discard all pending entries; first edge after release behaves as from an idle scoreboard.

Verification
REQ-031 Load x5 (latency 1) issued, next cycle add rs1=x5 -> stall=1 one cycle, then 0; stall_cycles=1.
REQ-032 ALU writes x7 (latency 0), next instruction reads x7 -> stall never asserted, busy[7] never set.
REQ-033 Mul writes x3 (latency 4), then consumer reads x3 -> stall=1 for 4 consecutive cycles, busy[3] falls the cycle stall drops.
REQ-034 Mul writes x9 (latency 4), then ALU writes x9 (latency 0) -> WAW stall until cnt[9]=0, then ALU issues.
REQ-035 Load to x0 then read x0; and consumer of busy x4 with flush=1 -> stall=0 both cases, x4 count still decrements.
REQ-036 Drive rst_n=0 asynchronously with cnt[6]=3 and stall_cycles=200 -> busy=0, stall_cycles=0 immediately; stall_cnt_clr during stall -> stall_cycles=0 next edge.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register result countdown scoreboard producing RAW/WAW stalls and a stall counter
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 3,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [REG_ADDR_W-1:0]   id_rs1,
  input  logic [REG_ADDR_W-1:0]   id_rs2,
  input  logic                    id_rs1_used,
  input  logic                    id_rs2_used,
  input  logic [REG_ADDR_W-1:0]   id_rd,
  input  logic                    id_reg_write,
  input  logic [LAT_W-1:0]        id_latency,
  input  logic                    flush,
  input  logic                    stall_cnt_clr,
  output logic                    stall,
  output logic                    hazard_detection_src,
  output logic [2**REG_ADDR_W-1:0] busy,
  output logic [CNT_W-1:0]        stall_cycles
);
  localparam int NUM_REGS = 2**REG_ADDR_W;
  logic [LAT_W-1:0] r_cnt [NUM_REGS];
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_raw_hit;
  logic             w_waw_hit;
  logic             w_live;
  logic             w_issue;
  // hazard detection from registered countdowns and the instruction now in ID
  always_comb begin
    w_raw_hit = (id_rs1_used && id_rs1 != '0 && r_cnt[id_rs1] != '0) ||
                (id_rs2_used && id_rs2 != '0 && r_cnt[id_rs2] != '0);
    w_waw_hit = id_reg_write && id_rd != '0 && r_cnt[id_rd] > id_latency;
    w_live    = id_valid && !flush;
    stall     = w_live && (w_raw_hit || w_waw_hit);
    w_issue   = w_live && !stall && id_reg_write && id_rd != '0;
    hazard_detection_src = !stall;
  end
  // countdowns: an issue reloads its destination, everything else drains toward 0; x0 never loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++)
        r_cnt[r] <= (w_issue && id_rd == REG_ADDR_W'(r)) ? id_latency :
                    (r_cnt[r] != '0) ? r_cnt[r] - LAT_W'(1) : '0;
    end
  end
  // saturating stall counter; clear has priority over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stall_cycles <= '0;
    else if (stall_cnt_clr) r_stall_cycles <= '0;
    else if (stall && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
  end
  genvar g;
  for (g = 0; g < NUM_REGS; g++) begin : g_busy
    assign busy[g] = r_cnt[g] != '0;
  end
  assign stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of the hazard scoreboard
module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs1_used, id_rs2_used, id_reg_write, flush, stall_cnt_clr;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_latency;
  logic        stall, hds, sat_stall, sat_hds;
  logic [31:0] busy, sat_busy;
  logic [15:0] stall_cycles;
  logic [3:0]  sat_cycles;
  int checks = 0;
  int failures = 0;
  int exp_sc;
  int n;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_latency(id_latency), .flush(flush),
    .stall_cnt_clr(stall_cnt_clr), .stall(stall), .hazard_detection_src(hds),
    .busy(busy), .stall_cycles(stall_cycles)
  );

  hazard_scoreboard #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_latency(id_latency), .flush(flush),
    .stall_cnt_clr(stall_cnt_clr), .stall(sat_stall), .hazard_detection_src(sat_hds),
    .busy(sat_busy), .stall_cycles(sat_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                     input logic u2, input logic [4:0] rd, input logic wr, input logic [2:0] lat,
                     input logic fl);
    id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_rd = rd; id_reg_write = wr; id_latency = lat; flush = fl;
    #1;
  endtask

  task automatic idle;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    stall_cnt_clr = 1'b0;
    idle();
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_stall_cycles", 32'(stall_cycles), 0);
    chk("reset_stall", 32'(stall), 0);
    chk("reset_hds", 32'(hds), 1);
    #4 rst_n = 1'b1;
    tick();
    // load x5 latency 1, consumer one bubble
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0);
    chk("load_issue_stall", 32'(stall), 0);
    tick();
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0);
    chk("load_use_stall", 32'(stall), 1);
    chk("load_use_hds", 32'(hds), 0);
    chk("load_busy5", 32'(busy[5]), 1);
    tick();
    chk("load_use_release", 32'(stall), 0);
    chk("load_stall_cycles", 32'(stall_cycles), 1);
    // ALU x7 latency 0, no stall
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0);
    tick();
    drv(1, 0, 0, 7, 1, 0, 0, 0, 0);
    chk("alu_use_stall", 32'(stall), 0);
    chk("alu_busy7", 32'(busy[7]), 0);
    tick();
    // mul x3 latency 4, consumer stalls 4 cycles
    drv(1, 0, 0, 0, 0, 3, 1, 4, 0);
    tick();
    drv(1, 3, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("mul_use_stall", 32'(stall), 1);
      chk("mul_busy3", 32'(busy[3]), 1);
      tick();
    end
    chk("mul_use_release", 32'(stall), 0);
    chk("mul_busy3_clear", 32'(busy[3]), 0);
    chk("mul_stall_cycles", 32'(stall_cycles), 5);
    // WAW: mul x9 latency 4 then ALU x9 latency 0
    drv(1, 0, 0, 0, 0, 9, 1, 4, 0);
    tick();
    drv(1, 0, 0, 0, 0, 9, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("waw_stall", 32'(stall), 1);
      tick();
    end
    chk("waw_release", 32'(stall), 0);
    tick();
    chk("waw_alu_busy9", 32'(busy[9]), 0);
    // WAW boundary: pending 2 vs new latency 1 stalls once; pending 1 vs 1 issues
    drv(1, 0, 0, 0, 0, 9, 1, 2, 0);
    tick();
    drv(1, 0, 0, 0, 0, 9, 1, 1, 0);
    chk("waw_bound_stall", 32'(stall), 1);
    tick();
    chk("waw_bound_equal", 32'(stall), 0);
    tick();
    idle();
    chk("waw_bound_busy9", 32'(busy[9]), 1);
    chk("waw_stall_cycles", 32'(stall_cycles), 10);
    tick();
    // x0 is never busy
    drv(1, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("x0_write_stall", 32'(stall), 0);
    tick();
    chk("x0_busy", busy, 0);
    drv(1, 0, 1, 0, 1, 0, 0, 0, 0);
    chk("x0_read_stall", 32'(stall), 0);
    tick();
    // flush hides the hazard and the issue; x4 keeps draining
    drv(1, 0, 0, 0, 0, 4, 1, 3, 0);
    tick();
    drv(1, 4, 1, 0, 0, 4, 1, 0, 1);
    chk("flush_stall", 32'(stall), 0);
    chk("flush_hds", 32'(hds), 1);
    chk("flush_busy4", 32'(busy[4]), 1);
    tick();
    idle();
    chk("flush_no_issue_busy4", 32'(busy[4]), 1);
    tick();
    chk("flush_drain_busy4", 32'(busy[4]), 1);
    tick();
    chk("flush_drained_busy4", 32'(busy[4]), 0);
    chk("flush_stall_cycles", 32'(stall_cycles), 10);
    // clear, then build exactly 200 stalled cycles
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    chk("clr_idle", 32'(stall_cycles), 0);
    exp_sc = 0;
    while (exp_sc < 200) begin
      drv(1, 0, 0, 0, 0, 8, 1, 7, 0);
      tick();
      drv(1, 8, 1, 0, 0, 0, 0, 0, 0);
      n = (200 - exp_sc < 7) ? 200 - exp_sc : 7;
      repeat (n) tick();
      exp_sc += n;
    end
    drv(1, 0, 0, 0, 0, 6, 1, 3, 0);
    tick();
    idle();
    chk("count_200", 32'(stall_cycles), 200);
    chk("sat_count", 32'(sat_cycles), 15);
    chk("pre_reset_busy6", 32'(busy[6]), 1);
    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_stall_cycles", 32'(stall_cycles), 0);
    #2 rst_n = 1'b1;
    tick();
    drv(1, 6, 1, 8, 1, 0, 0, 0, 0);
    chk("post_reset_stall", 32'(stall), 0);
    tick();
    // clear during a stall wins over the increment
    drv(1, 0, 0, 0, 0, 3, 1, 4, 0);
    tick();
    drv(1, 3, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("pre_clr_count", 32'(stall_cycles), 1);
    stall_cnt_clr = 1'b1;
    #1;
    chk("clr_during_stall", 32'(stall), 1);
    tick();
    chk("clr_wins", 32'(stall_cycles), 0);
    stall_cnt_clr = 1'b0;
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
